bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-in, serial-out stage that feeds the 1101 sequence detector. It accepts one NUM_BITS-wide word through a valid/ready handshake. It presents the word one bit at a time on `serial_out`, holding each bit until a `shift_strobe` tick. It drives a fixed idle level of 0 between words, so the downstream Moore detector never sees spurious 1s.

## Interface
- NUM_BITS, 8: data bits per word; legal range 2–32.
- MSB_FIRST, 1: 1 sends bit NUM_BITS-1 first; 0 sends bit 0 first.
- clk  input  1  system clock; all state changes on its rising edge.
- n_rst  input  1  asynchronous active-low reset; one clock domain, `clk`.
- data_in  input  NUM_BITS  word to serialize; sampled only on an accepted load.
- load_valid  input  1  word on `data_in` is valid.
- load_ready  output  1  block can accept a word.
- shift_strobe  input  1  single-cycle bit-rate tick; advance to the next bit.
- serial_out  output  1  serial bit stream to the detector's `i`.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse after the final bit is consumed.

## Operation
- States (shared enum): IDLE, SHIFT, DONE. Registers: `shift_reg` [NUM_BITS-1:0], `bit_cnt` [$clog2(NUM_BITS+1)-1:0], state.
- IDLE:
  - `load_ready`=1, `busy`=0, `serial_out`=0.
  - Load accepted when `load_valid && load_ready`: `shift_reg` ← `data_in`, `bit_cnt` ← 0, go to SHIFT.
- SHIFT:
  - `load_ready`=0, `busy`=1.
  - `serial_out` = `shift_reg[NUM_BITS-1]` when MSB_FIRST=1, else `shift_reg[0]`.
  - On `shift_strobe`:
    - If `bit_cnt` == last index, go to DONE.
    - Otherwise shift (left when MSB_FIRST=1, right otherwise, fill 0) and increment `bit_cnt`.
  - Without a strobe, all registers hold.
- DONE:
  - `done`=1, `busy`=0, `load_ready`=0, `serial_out`=0.
  - Unconditionally returns to IDLE next cycle.
- Boundary rules:
  - `load_valid` outside IDLE is ignored; no word is queued.
  - `shift_strobe` in IDLE or DONE is ignored.
  - `shift_strobe` and `load_valid` in the same IDLE cycle: the load is taken and the strobe is ignored. The first bit always gets at least one full strobe period.
  - `data_in` changes after acceptance have no effect.
  - Reset mid-word aborts the word with no `done` pulse.
- All outputs are decoded from registered state (Moore); there is no combinational path from inputs to outputs.

## Timing
- Reset values: state=IDLE, `shift_reg`=0, `bit_cnt`=0.
- Output values under reset: `load_ready`=1, `busy`=0, `done`=0, `serial_out`=0.
- Load accepted at edge t: the first bit appears on `serial_out` in cycle t+1.
- Bit k is held from the edge after strobe k-1 until the edge of strobe k.
- Strobe on every cycle: a word occupies NUM_BITS cycles in SHIFT, plus 1 cycle in DONE.
- Minimum load-to-load spacing is NUM_BITS+2 cycles, with `serial_out`=0 for at least 2 cycles between words (DONE and IDLE).

## Configuration
- `BIT_SERIALIZER_PARITY_EN` defined:
  - An even-parity bit (XOR of the accepted word, captured at load) is sent after the last data bit.
  - `bit_cnt` counts to NUM_BITS.
  - `done` pulses after the parity bit is consumed.
- Undefined: exactly NUM_BITS bits are sent, with no parity logic.

## Structure
- Package `serializer_pkg`:
  - the `ser_state_t` enum {IDLE, SHIFT, DONE}, 2-bit;
  - the constant `SER_IDLE_LEVEL` = 1'b0.
- Sub-module `bit_counter`:
  - parameterized width;
  - async active-low reset, synchronous clear, count enable, and rollover value input;
  - asserts `last` when count == rollover value.
- Top level holds the FSM, the shift register and the output decode.

## Test plan
- Reset held, then released with `load_valid`=0: `load_ready`=1, `busy`=0, `done`=0, `serial_out`=0 indefinitely.
- Load 8'hD0, MSB_FIRST=1, strobe every cycle: `serial_out` = 1,1,0,1,0,0,0,0 on cycles t+1..t+8; `done` at t+9. The downstream detector output goes high exactly once.
- Load 8'h0B, MSB_FIRST=0, strobe every 4th cycle: LSB-first sequence 1,1,0,1,0,0,0,0. Each bit is held 4 cycles.
- Same-cycle events:
  - `load_valid` pulses during SHIFT with `data_in`=8'hFF: ignored, the in-flight word is unchanged.
  - Strobe and load in the same IDLE cycle: first bit still held until the next strobe.
- Reset asserted after 3 bits of 8'hD0: `serial_out`=0 and state=IDLE immediately; no `done`. The next load of 8'hA5 sends correctly.
- With `BIT_SERIALIZER_PARITY_EN`:
  - 8'hD0 sends 9 bits, parity bit 1;
  - 8'hC0 sends parity bit 0;
  - `done` arrives one strobe later than without the macro.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared FSM state type and idle line level for bit_serializer
package serializer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;
  localparam logic SER_IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/bit_counter.sv
// bit_counter: up-counter with sync clear and enable, flags when count equals the rollover value
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
  assign last = cnt == max_val;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: strobe-paced parallel-to-serial word sender; BIT_SERIALIZER_PARITY_EN appends an even-parity bit
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                shift_strobe,
  output logic                serial_out,
  output logic                busy,
  output logic                done
);
  localparam int CW = $clog2(NUM_BITS + 1);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS);
`else
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
`endif
  ser_state_t state, state_nx;
  logic [NUM_BITS-1:0] shift_reg;
  logic last, load, step, data_bit, out_bit;
  assign load = state == IDLE && load_valid;
  assign step = state == SHIFT && shift_strobe && !last;
  bit_counter #(.W(CW)) u_bit_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (load),
    .en      (step),
    .max_val (LAST),
    .last    (last)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_valid) state_nx = SHIFT;
      SHIFT:   if (shift_strobe && last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) shift_reg <= '0;
    else if (load) shift_reg <= data_in;
    else if (step) shift_reg <= MSB_FIRST ? {shift_reg[NUM_BITS-2:0], 1'b0} : {1'b0, shift_reg[NUM_BITS-1:1]};
  assign data_bit = MSB_FIRST ? shift_reg[NUM_BITS-1] : shift_reg[0];
`ifdef BIT_SERIALIZER_PARITY_EN
  logic parity;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) parity <= 1'b0;
    else if (load) parity <= ^data_in;
  assign out_bit = last ? parity : data_bit;
`else
  assign out_bit = data_bit;
`endif
  assign serial_out = state == SHIFT ? out_bit : SER_IDLE_LEVEL;
  assign load_ready = state == IDLE;
  assign busy       = state == SHIFT;
  assign done       = state == DONE;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized self-checking bench for MSB-first and LSB-first bit_serializer instances
module tb_bit_serializer;
  localparam int NB = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NS = NB + 1;
`else
  localparam int NS = NB;
`endif
  localparam logic [7:0] IDLE_V = 8'b1000_1000;
  localparam logic [7:0] DONE_V = 8'b0010_0010;
  logic clk = 1'b0, n_rst = 1'b0, load_valid = 1'b0, shift_strobe = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic lr_m, bz_m, dn_m, so_m, lr_l, bz_l, dn_l, so_l;
  int vectors = 0, errors = 0;
  bit so_q[$];
  always #5 clk = ~clk;
  bit_serializer #(.NUM_BITS(NB), .MSB_FIRST(1)) dut_m (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .load_valid(load_valid), .load_ready(lr_m),
    .shift_strobe(shift_strobe), .serial_out(so_m), .busy(bz_m), .done(dn_m)
  );
  bit_serializer #(.NUM_BITS(NB), .MSB_FIRST(0)) dut_l (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .load_valid(load_valid), .load_ready(lr_l),
    .shift_strobe(shift_strobe), .serial_out(so_l), .busy(bz_l), .done(dn_l)
  );
  function automatic logic [7:0] obs();
    return {lr_m, bz_m, dn_m, so_m, lr_l, bz_l, dn_l, so_l};
  endfunction
  task automatic send(input logic [NB-1:0] d, input int p, input bit same_strobe, input bit noise,
                      input int abort_at, input string nm);
    bit em[NS], el[NS];
    logic [7:0] want;
    for (int j = 0; j < NB; j++) begin
      em[j] = d[NB-1-j];
      el[j] = d[j];
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    em[NB] = ^d;
    el[NB] = ^d;
`endif
    vectors++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL %s pre-load: got %b want %b", nm, obs(), IDLE_V);
    end
    so_q.push_back(so_m);
    data_in = d;
    load_valid = 1'b1;
    shift_strobe = same_strobe;
    @(negedge clk);
    load_valid = 1'b0;
    shift_strobe = 1'b0;
    data_in = NB'($urandom);
    for (int j = 0; j < NS; j++)
      for (int c = 0; c < p; c++) begin
        if (j == abort_at) begin
          n_rst = 1'b0;
          #1;
          vectors++;
          if (obs() !== IDLE_V) begin
            errors++;
            $display("FAIL %s reset-abort: got %b want %b", nm, obs(), IDLE_V);
          end
          @(negedge clk);
          n_rst = 1'b1;
          repeat (3) begin
            vectors++;
            if (obs() !== IDLE_V) begin
              errors++;
              $display("FAIL %s post-abort idle: got %b want %b", nm, obs(), IDLE_V);
            end
            @(negedge clk);
          end
          return;
        end
        want = {3'b010, em[j], 3'b010, el[j]};
        vectors++;
        if (obs() !== want) begin
          errors++;
          $display("FAIL %s bit%0d cyc%0d: got %b want %b", nm, j, c, obs(), want);
        end
        so_q.push_back(so_m);
        shift_strobe = c == p - 1;
        if (noise) begin
          load_valid = 1'($urandom);
          data_in = '1;
        end
        @(negedge clk);
      end
    load_valid = 1'b0;
    shift_strobe = 1'($urandom);
    vectors++;
    if (obs() !== DONE_V) begin
      errors++;
      $display("FAIL %s done: got %b want %b", nm, obs(), DONE_V);
    end
    so_q.push_back(so_m);
    @(negedge clk);
    shift_strobe = 1'b0;
    vectors++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL %s post-done idle: got %b want %b", nm, obs(), IDLE_V);
    end
    so_q.push_back(so_m);
  endtask
  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs() !== IDLE_V) begin
      errors++;
      $display("FAIL reset held: got %b want %b", obs(), IDLE_V);
    end
    n_rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (obs() !== IDLE_V) begin
        errors++;
        $display("FAIL reset released idle: got %b want %b", obs(), IDLE_V);
      end
    end
  endtask
  task automatic test_msb_known();
    int hits = 0;
    so_q.delete();
    send(8'hD0, 1, 1'b0, 1'b0, -1, "msb_d0");
    for (int i = 3; i < so_q.size(); i++)
      if (so_q[i-3] && so_q[i-2] && !so_q[i-1] && so_q[i]) hits++;
    vectors++;
    if (hits !== 1) begin
      errors++;
      $display("FAIL detector_hits: got %0d want 1", hits);
    end
  endtask
  task automatic test_lsb_known();
    send(8'h0B, 4, 1'b0, 1'b0, -1, "lsb_0b");
    send(8'hC0, 1, 1'b0, 1'b0, -1, "c0");
  endtask
  task automatic test_ignored_load();
    send(8'hD0, 2, 1'b0, 1'b1, -1, "load_during_shift");
  endtask
  task automatic test_same_cycle();
    send(8'hA5, 3, 1'b1, 1'b0, -1, "strobe_with_load");
  endtask
  task automatic test_reset_mid();
    send(8'hD0, 1, 1'b0, 1'b0, 3, "abort_d0");
    send(8'hA5, 1, 1'b0, 1'b0, -1, "after_abort_a5");
  endtask
  task automatic test_back_to_back();
    repeat (20) send(NB'($urandom), $urandom_range(1, 4), 1'($urandom), 1'($urandom), -1, "random");
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_msb_known();
    test_lsb_known();
    test_ignored_load();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
